// File: rtl/xbar_arb_nto1_if.sv
// Bus bundle for the N-to-1 TileLink arbiter: per-master A/D channels plus the
// merged slave-side A/D channel. "master" is the surrounding fabric, "slave" the arbiter.
interface xbar_arb_nto1_if #(
  parameter int NUM_MASTERS  = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SIZE_WIDTH   = 3,
  parameter int SRC_WIDTH    = 2,
  parameter int MIDX_W       = $clog2(NUM_MASTERS),
  parameter int SINK_WIDTH   = 1,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int WSRC       = SRC_WIDTH + MIDX_W;

  // master-side A
  logic [NUM_MASTERS-1:0]                   a_valid;
  logic [NUM_MASTERS-1:0]                   a_ready;
  logic [NUM_MASTERS-1:0][OPCODE_WIDTH-1:0] a_opcode;
  logic [NUM_MASTERS-1:0][PARAM_WIDTH-1:0]  a_param;
  logic [NUM_MASTERS-1:0][SIZE_WIDTH-1:0]   a_size;
  logic [NUM_MASTERS-1:0][SRC_WIDTH-1:0]    a_source;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]   a_address;
  logic [NUM_MASTERS-1:0][MASK_WIDTH-1:0]   a_mask;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   a_data;
  // master-side D
  logic [NUM_MASTERS-1:0]                   d_valid;
  logic [NUM_MASTERS-1:0]                   d_ready;
  logic [NUM_MASTERS-1:0][OPCODE_WIDTH-1:0] d_opcode;
  logic [NUM_MASTERS-1:0][PARAM_WIDTH-1:0]  d_param;
  logic [NUM_MASTERS-1:0][SIZE_WIDTH-1:0]   d_size;
  logic [NUM_MASTERS-1:0][SRC_WIDTH-1:0]    d_source;
  logic [NUM_MASTERS-1:0][SINK_WIDTH-1:0]   d_sink;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   d_data;
  logic [NUM_MASTERS-1:0]                   d_error;
  // slave-side A
  logic                    a_valid_out;
  logic                    a_ready_out;
  logic [OPCODE_WIDTH-1:0] a_opcode_out;
  logic [PARAM_WIDTH-1:0]  a_param_out;
  logic [SIZE_WIDTH-1:0]   a_size_out;
  logic [WSRC-1:0]         a_source_out;
  logic [ADDR_WIDTH-1:0]   a_address_out;
  logic [MASK_WIDTH-1:0]   a_mask_out;
  logic [DATA_WIDTH-1:0]   a_data_out;
  // slave-side D
  logic                    d_valid_in;
  logic                    d_ready_in;
  logic [OPCODE_WIDTH-1:0] d_opcode_in;
  logic [PARAM_WIDTH-1:0]  d_param_in;
  logic [SIZE_WIDTH-1:0]   d_size_in;
  logic [WSRC-1:0]         d_source_in;
  logic [SINK_WIDTH-1:0]   d_sink_in;
  logic [DATA_WIDTH-1:0]   d_data_in;
  logic                    d_error_in;
  logic                    drop_pulse;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
    output d_ready,
    input  a_valid_out, a_opcode_out, a_param_out, a_size_out, a_source_out,
           a_address_out, a_mask_out, a_data_out,
    output a_ready_out,
    output d_valid_in, d_opcode_in, d_param_in, d_size_in, d_source_in, d_sink_in,
           d_data_in, d_error_in,
    input  d_ready_in, drop_pulse
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
    input  d_ready,
    output a_valid_out, a_opcode_out, a_param_out, a_size_out, a_source_out,
           a_address_out, a_mask_out, a_data_out,
    input  a_ready_out,
    input  d_valid_in, d_opcode_in, d_param_in, d_size_in, d_source_in, d_sink_in,
           d_data_in, d_error_in,
    output d_ready_in, drop_pulse
  );
endinterface

// File: rtl/xbar_arb_nto1.sv
// N-to-1 TileLink A-channel arbiter with grant locking, source widening,
// per-master outstanding caps and index-routed D responses.

module xbar_arb_nto1_ocnt #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)                                          r_cnt <= '0;
    else if (i_inc && !i_dec && r_cnt < CW'(MAX_OUTSTANDING)) r_cnt <= r_cnt + CW'(1);
    else if (i_dec && !i_inc && r_cnt != '0)            r_cnt <= r_cnt - CW'(1);
  end

  assign o_full = (r_cnt >= CW'(MAX_OUTSTANDING));
endmodule

module xbar_arb_nto1 #(
  parameter int NUM_MASTERS     = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int SIZE_WIDTH      = 3,
  parameter int SRC_WIDTH       = 2,
  parameter int MIDX_W          = $clog2(NUM_MASTERS),
  parameter int SINK_WIDTH      = 1,
  parameter int OPCODE_WIDTH    = 3,
  parameter int PARAM_WIDTH     = 3,
  parameter int ARB_MODE        = 0,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             reset,
  xbar_arb_nto1_if.slave   bus
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int LG_BYTES   = $clog2(MASK_WIDTH);
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PART = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACK_DATA = OPCODE_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_BURST} state_t;

  function automatic logic [7:0] f_beats(input logic [SIZE_WIDTH-1:0] sz);
    if (int'(sz) <= LG_BYTES) return 8'd1;
    return 8'(32'd1 << (int'(sz) - LG_BYTES));
  endfunction

  function automatic logic [MIDX_W-1:0] f_next(input logic [MIDX_W-1:0] i);
    return (int'(i) == NUM_MASTERS - 1) ? '0 : i + MIDX_W'(1);
  endfunction

  function automatic int f_cand(input logic [MIDX_W-1:0] ptr, input int i);
    if (ARB_MODE == 1) return i;
    return (int'(ptr) + i) % NUM_MASTERS;
  endfunction

  state_t            r_state;
  logic [MIDX_W-1:0] r_lock, r_rr_ptr;
  logic [7:0]        r_beats_left, r_d_beats_left;

  logic [NUM_MASTERS-1:0] w_elig, w_full, w_inc, w_dec;
  logic                    w_any, w_sel_vld, w_hs, w_multi;
  logic [MIDX_W-1:0]       w_win, w_sel;
  logic [7:0]              w_a_beats;
  logic [OPCODE_WIDTH-1:0] w_a_opcode;
  logic [PARAM_WIDTH-1:0]  w_a_param;
  logic [SIZE_WIDTH-1:0]   w_a_size;
  logic [SRC_WIDTH-1:0]    w_a_src;
  logic [ADDR_WIDTH-1:0]   w_a_addr;
  logic [MASK_WIDTH-1:0]   w_a_mask;
  logic [DATA_WIDTH-1:0]   w_a_data;

  assign w_elig = bus.a_valid & ~w_full;

  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!w_any && w_elig[f_cand(r_rr_ptr, i)]) begin
        w_any = 1'b1;
        w_win = MIDX_W'(f_cand(r_rr_ptr, i));
      end
    end
  end

  // Once a request is shown to the slave it stays locked until it handshakes.
  assign w_sel     = (r_state == S_IDLE) ? w_win : r_lock;
  assign w_sel_vld = (r_state == S_IDLE) ? w_any : bus.a_valid[r_lock];

  assign w_a_opcode = bus.a_opcode[w_sel];
  assign w_a_param  = bus.a_param[w_sel];
  assign w_a_size   = bus.a_size[w_sel];
  assign w_a_src    = bus.a_source[w_sel];
  assign w_a_addr   = bus.a_address[w_sel];
  assign w_a_mask   = bus.a_mask[w_sel];
  assign w_a_data   = bus.a_data[w_sel];

  assign bus.a_valid_out   = !reset && w_sel_vld;
  assign bus.a_opcode_out  = w_a_opcode;
  assign bus.a_param_out   = w_a_param;
  assign bus.a_size_out    = w_a_size;
  assign bus.a_source_out  = {w_sel, w_a_src};
  assign bus.a_address_out = w_a_addr;
  assign bus.a_mask_out    = w_a_mask;
  assign bus.a_data_out    = w_a_data;

  assign w_hs      = bus.a_valid_out && bus.a_ready_out;
  assign w_a_beats = f_beats(w_a_size);
  assign w_multi   = (w_a_opcode == OP_PUT_FULL || w_a_opcode == OP_PUT_PART) && (w_a_beats != 8'd1);

  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      bus.a_ready[m] = !reset && bus.a_ready_out && (w_sel == MIDX_W'(m))
                       && (r_state != S_IDLE || w_any);
      w_inc[m]       = w_hs && (r_state != S_BURST) && (w_sel == MIDX_W'(m));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lock       <= '0;
      r_rr_ptr     <= '0;
      r_beats_left <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_lock <= w_win;
          if (!bus.a_ready_out) r_state <= S_HOLD;
          else if (w_multi) begin
            r_state      <= S_BURST;
            r_beats_left <= w_a_beats - 8'd1;
          end else r_rr_ptr <= f_next(w_win);
        end
        S_HOLD: if (w_hs) begin
          if (w_multi) begin
            r_state      <= S_BURST;
            r_beats_left <= w_a_beats - 8'd1;
          end else begin
            r_state  <= S_IDLE;
            r_rr_ptr <= f_next(r_lock);
          end
        end
        S_BURST: if (w_hs) begin
          r_beats_left <= r_beats_left - 8'd1;
          if (r_beats_left == 8'd1) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= f_next(r_lock);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // D side: route by the master index carried in the widened source.
  logic [MIDX_W-1:0]     w_didx;
  logic                  w_d_inrange, w_d_hs, w_d_last;
  logic [7:0]            w_d_total;
  logic [SINK_WIDTH-1:0] w_d_sink;
  logic [SRC_WIDTH-1:0]  w_d_src;

  assign w_didx      = bus.d_source_in[SRC_WIDTH +: MIDX_W];
  assign w_d_inrange = {1'b0, w_didx} < (MIDX_W+1)'(NUM_MASTERS);
  assign w_d_sink    = bus.d_sink_in;
  assign w_d_src     = bus.d_source_in[SRC_WIDTH-1:0];

  assign bus.d_ready_in = !reset && (w_d_inrange ? bus.d_ready[w_didx] : 1'b1);
  assign bus.drop_pulse = !reset && bus.d_valid_in && !w_d_inrange;

  assign w_d_hs    = bus.d_valid_in && bus.d_ready_in;
  assign w_d_total = (bus.d_opcode_in == OP_ACK_DATA) ? f_beats(bus.d_size_in) : 8'd1;
  assign w_d_last  = (r_d_beats_left == 8'd0) ? (w_d_total == 8'd1) : (r_d_beats_left == 8'd1);

  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      bus.d_valid[m]  = !reset && bus.d_valid_in && w_d_inrange && (w_didx == MIDX_W'(m));
      w_dec[m]        = w_d_hs && w_d_last && w_d_inrange && (w_didx == MIDX_W'(m));
      bus.d_opcode[m] = bus.d_opcode_in;
      bus.d_param[m]  = bus.d_param_in;
      bus.d_size[m]   = bus.d_size_in;
      bus.d_source[m] = w_d_src;
      bus.d_sink[m]   = w_d_sink;
      bus.d_data[m]   = bus.d_data_in;
      bus.d_error[m]  = bus.d_error_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                        r_d_beats_left <= '0;
    else if (w_d_hs) begin
      if (w_d_last)                   r_d_beats_left <= '0;
      else if (r_d_beats_left == '0)  r_d_beats_left <= w_d_total - 8'd1;
      else                            r_d_beats_left <= r_d_beats_left - 8'd1;
    end
  end

  xbar_arb_nto1_ocnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_ocnt [NUM_MASTERS-1:0] (
    .clk    (clk),
    .reset  (reset),
    .i_inc  (w_inc),
    .i_dec  (w_dec),
    .o_full (w_full)
  );
endmodule

// File: tb/tb_xbar_arb_nto1.sv
// Directed bench: a vector table for arbitration/limits plus hand sequences
// for HOLD, bursts, D routing, drops and reset mid-burst.
module tb_xbar_arb_nto1;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  xbar_arb_nto1_if #(.NUM_MASTERS(4)) bus ();
  xbar_arb_nto1_if #(.NUM_MASTERS(3)) bus2 ();

  xbar_arb_nto1 #(.NUM_MASTERS(4), .ARB_MODE(0), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  xbar_arb_nto1 #(.NUM_MASTERS(3), .ARB_MODE(1), .MAX_OUTSTANDING(4)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] vld;
    logic       rdy;
    logic       exp_vout;
    logic [3:0] exp_rdy;
    logic [3:0] exp_src;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.a_valid = '0;  bus.a_ready_out = 1'b0;
    bus.d_valid_in = 1'b0; bus.d_ready = '0; bus.d_source_in = '0;
    bus.d_opcode_in = '0; bus.d_param_in = '0; bus.d_size_in = 3'd2;
    bus.d_sink_in = '0; bus.d_data_in = '0; bus.d_error_in = 1'b0;
    bus2.a_valid = '0; bus2.a_ready_out = 1'b0;
    bus2.d_valid_in = 1'b0; bus2.d_ready = '0; bus2.d_source_in = '0;
    bus2.d_opcode_in = '0; bus2.d_param_in = '0; bus2.d_size_in = 3'd2;
    bus2.d_sink_in = '0; bus2.d_data_in = '0; bus2.d_error_in = 1'b0;
  endtask

  task automatic init_fields();
    for (int m = 0; m < 4; m++) begin
      bus.a_opcode[m] = 3'd4;  bus.a_param[m] = '0;  bus.a_size[m] = 3'd2;
      bus.a_source[m] = 2'(3 - m);
      bus.a_address[m] = 32'(32'h1000 * (m + 1));
      bus.a_mask[m] = '1;
      bus.a_data[m] = 32'(32'hA0 + m);
    end
    for (int m = 0; m < 3; m++) begin
      bus2.a_opcode[m] = 3'd4; bus2.a_param[m] = '0; bus2.a_size[m] = 3'd2;
      bus2.a_source[m] = 2'(m);
      bus2.a_address[m] = 32'(32'h100 * m);
      bus2.a_mask[m] = '1;
      bus2.a_data[m] = '0;
    end
  endtask

  // Reset with every input active: all handshake outputs must be held low.
  task automatic do_reset();
    reset = 1'b1;
    bus.a_valid = '1; bus.a_ready_out = 1'b1;
    bus.d_valid_in = 1'b1; bus.d_ready = '1; bus.d_source_in = 4'b0000;
    bus2.d_valid_in = 1'b1; bus2.d_source_in = 4'b1101;
    smp();
    chk("rst_a_valid_out", bus.a_valid_out, 0);
    chk("rst_a_ready", bus.a_ready, 0);
    chk("rst_d_valid", bus.d_valid, 0);
    chk("rst_d_ready_in", bus.d_ready_in, 0);
    chk("rst_drop_pulse", bus2.drop_pulse, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    init_fields();
    // {a_valid, a_ready_out, exp a_valid_out, exp a_ready, exp a_source_out}
    tbl[0]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 4'd3};
    tbl[1]  = '{4'b1111, 1'b1, 1'b1, 4'b0010, 4'd6};
    tbl[2]  = '{4'b1111, 1'b1, 1'b1, 4'b0100, 4'd9};
    tbl[3]  = '{4'b1111, 1'b1, 1'b1, 4'b1000, 4'd12};
    tbl[4]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 4'd3};
    tbl[5]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 4'd0};
    tbl[6]  = '{4'b0011, 1'b1, 1'b1, 4'b0010, 4'd6};
    tbl[7]  = '{4'b0011, 1'b1, 1'b0, 4'b0000, 4'd0};
    tbl[8]  = '{4'b1001, 1'b0, 1'b1, 4'b0000, 4'd12};
    tbl[9]  = '{4'b1111, 1'b0, 1'b1, 4'b0000, 4'd12};
    tbl[10] = '{4'b1111, 1'b1, 1'b1, 4'b1000, 4'd12};
    tbl[11] = '{4'b1111, 1'b1, 1'b1, 4'b0100, 4'd9};
    tbl[12] = '{4'b1111, 1'b1, 1'b0, 4'b0000, 4'd0};

    do_reset();

    for (int i = 0; i < 13; i++) begin
      bus.a_valid = tbl[i].vld;
      bus.a_ready_out = tbl[i].rdy;
      smp();
      chk($sformatf("v%0d_a_valid_out", i), bus.a_valid_out, tbl[i].exp_vout);
      chk($sformatf("v%0d_a_ready", i), bus.a_ready, tbl[i].exp_rdy);
      if (tbl[i].exp_vout) chk($sformatf("v%0d_a_source_out", i), bus.a_source_out, tbl[i].exp_src);
      tick();
    end

    // AccessAck to master 0 frees one slot; granted on the following cycle.
    bus.a_valid = 4'b0001; bus.a_ready_out = 1'b1;
    bus.d_valid_in = 1'b1; bus.d_opcode_in = 3'd0; bus.d_source_in = 4'b0011; bus.d_ready = 4'b0001;
    smp();
    chk("lim_blocked", bus.a_valid_out, 0);
    chk("ack0_d_valid", bus.d_valid, 4'b0001);
    chk("ack0_d_ready_in", bus.d_ready_in, 1);
    chk("ack0_d_source", bus.d_source[0], 2'd3);
    tick();
    bus.d_valid_in = 1'b0;
    smp();
    chk("lim_regrant_vout", bus.a_valid_out, 1);
    chk("lim_regrant_ready", bus.a_ready, 4'b0001);
    tick();
    bus.a_valid = '0;

    // Route {3,1}: only master 3 sees it; its ready drives d_ready_in.
    bus.d_valid_in = 1'b1; bus.d_source_in = 4'b1101; bus.d_ready = 4'b0000;
    smp();
    chk("rt3_d_valid", bus.d_valid, 4'b1000);
    chk("rt3_d_ready_in_lo", bus.d_ready_in, 0);
    bus.d_ready = 4'b1000;
    smp();
    chk("rt3_d_ready_in_hi", bus.d_ready_in, 1);
    chk("rt3_d_source", bus.d_source[3], 2'd1);
    chk("rt3_drop", bus.drop_pulse, 0);
    tick();
    bus.d_valid_in = 1'b0;

    // 4-beat AccessAckData to master 1: its slot frees only after the last beat.
    bus.a_valid = 4'b0010; bus.a_ready_out = 1'b0;
    bus.d_opcode_in = 3'd1; bus.d_size_in = 3'd4; bus.d_source_in = 4'b0110;
    bus.d_ready = 4'b0010; bus.d_valid_in = 1'b1;
    for (int b = 0; b < 4; b++) begin
      smp();
      chk($sformatf("dburst_b%0d_blocked", b), bus.a_valid_out, 0);
      chk($sformatf("dburst_b%0d_d_valid", b), bus.d_valid, 4'b0010);
      tick();
    end
    bus.d_valid_in = 1'b0;
    smp();
    chk("dburst_freed_vout", bus.a_valid_out, 1);
    chk("dburst_freed_src", bus.a_source_out, 4'd6);
    tick();
    bus.a_ready_out = 1'b1;
    smp();
    chk("dburst_hold_ready", bus.a_ready, 4'b0010);
    tick();

    // HOLD: master 2 stalled three cycles while master 0 asserts.
    do_reset();
    bus.a_valid = 4'b0100; bus.a_ready_out = 1'b0;
    smp();
    chk("hold_c0_src", bus.a_source_out, 4'd9);
    chk("hold_c0_addr", bus.a_address_out, 32'h3000);
    chk("hold_c0_ready", bus.a_ready, 4'b0000);
    tick();
    bus.a_valid = 4'b0101;
    for (int c = 1; c < 3; c++) begin
      smp();
      chk($sformatf("hold_c%0d_vout", c), bus.a_valid_out, 1);
      chk($sformatf("hold_c%0d_src", c), bus.a_source_out, 4'd9);
      chk($sformatf("hold_c%0d_ready", c), bus.a_ready, 4'b0000);
      tick();
    end
    bus.a_ready_out = 1'b1;
    smp();
    chk("hold_hs_ready", bus.a_ready, 4'b0100);
    tick();
    bus.a_valid = 4'b0001;
    smp();
    chk("hold_after_ready", bus.a_ready, 4'b0001);
    tick();
    bus.a_valid = '0;

    // A-side burst: 4 beats of master 1 before master 3 gets in.
    do_reset();
    bus.a_opcode[1] = 3'd0; bus.a_size[1] = 3'd4;
    bus.a_valid = 4'b1010; bus.a_ready_out = 1'b1;
    for (int c = 0; c < 5; c++) begin
      smp();
      chk($sformatf("burst_c%0d_ready", c), bus.a_ready, (c < 4) ? 4'b0010 : 4'b1000);
      chk($sformatf("burst_c%0d_src", c), bus.a_source_out, (c < 4) ? 4'd6 : 4'd12);
      if (c == 0) chk("burst_data", bus.a_data_out, 32'hA1);
      tick();
    end
    bus.a_valid = '0;

    // Reset after beat 2 of 4 aborts the burst and clears the counters.
    do_reset();
    bus.a_valid = 4'b0010; bus.a_ready_out = 1'b1;
    tick(); tick();
    do_reset();
    bus.a_opcode[1] = 3'd4; bus.a_size[1] = 3'd2;
    bus.a_valid = 4'b0001; bus.a_ready_out = 1'b1;
    smp();
    chk("postrst_idle_ready", bus.a_ready, 4'b0001);
    tick();
    bus.a_valid = 4'b0010;
    smp();
    chk("postrst_get1", bus.a_ready, 4'b0010);
    tick();
    smp();
    chk("postrst_get2", bus.a_ready, 4'b0010);
    tick();
    smp();
    chk("postrst_full", bus.a_valid_out, 0);
    bus.a_valid = '0;

    // Three-master instance: drops and fixed priority.
    bus2.d_valid_in = 1'b1; bus2.d_source_in = 4'b1101; bus2.d_ready = 3'b000;
    smp();
    chk("drop_d_ready_in", bus2.d_ready_in, 1);
    chk("drop_pulse", bus2.drop_pulse, 1);
    chk("drop_d_valid", bus2.d_valid, 3'b000);
    bus2.d_source_in = 4'b1001; bus2.d_ready = 3'b100;
    smp();
    chk("rt2_d_valid", bus2.d_valid, 3'b100);
    chk("rt2_drop", bus2.drop_pulse, 0);
    chk("rt2_d_ready_in", bus2.d_ready_in, 1);
    tick();
    bus2.d_valid_in = 1'b0;
    bus2.a_valid = 3'b110; bus2.a_ready_out = 1'b1;
    for (int c = 0; c < 2; c++) begin
      smp();
      chk($sformatf("fp_c%0d_ready", c), bus2.a_ready, 3'b010);
      chk($sformatf("fp_c%0d_src", c), bus2.a_source_out, 4'd5);
      tick();
    end
    bus2.a_valid = 3'b111;
    smp();
    chk("fp_low_wins", bus2.a_ready, 3'b001);
    chk("fp_low_src", bus2.a_source_out, 4'd0);
    tick();
    bus2.a_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/xbar_arb_nto1.md
# xbar_arb_nto1

Parametrised N-to-1 TileLink crossbar front-end that merges `NUM_MASTERS` master A channels onto one slave-side port and routes D responses back. It is the next generation of the main-crossbar arbiter. It adds:
- selectable round-robin or fixed-priority arbitration;
- grant locking across back-pressure and multi-beat Put bursts;
- source-ID widening with the master index, so responses route without a lookup;
- per-master outstanding-request limits.

It sits between the master sockets and the CDC adapter.

## Interface
- `NUM_MASTERS`, 4: number of master ports (≥2).
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width; `MASK_WIDTH` = `DATA_WIDTH/8`.
- `SIZE_WIDTH`, 3: `a_size`/`d_size` width (log2 bytes).
- `SRC_WIDTH`, 2: master-side source width.
- `MIDX_W`, `$clog2(NUM_MASTERS)`: master-index field width.
- `SINK_WIDTH`, 1; `OPCODE_WIDTH`, 3; `PARAM_WIDTH`, 3: field widths.
- `ARB_MODE`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `MAX_OUTSTANDING`, 4: per-master cap on requests awaiting a response (≥1).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `a_valid`/`a_ready` in/out `NUM_MASTERS`: per-master A handshake.
- `a_opcode`, `a_param`, `a_size`, `a_source`, `a_address`, `a_mask`, `a_data` in `NUM_MASTERS`×field: concatenated master A fields; master m occupies slice m.
- `d_valid` out `NUM_MASTERS`; `d_ready` in `NUM_MASTERS`: per-master D handshake.
- `d_opcode`, `d_param`, `d_size`, `d_source`, `d_sink`, `d_data` out `NUM_MASTERS`×field; `d_error` out `NUM_MASTERS`: D fields broadcast to all masters. `d_source` slice = low `SRC_WIDTH` bits of `d_source_in`.
- `a_valid_out` out 1; `a_ready_out` in 1: slave-side A handshake.
- `a_opcode_out`, `a_param_out`, `a_size_out`, `a_address_out`, `a_mask_out`, `a_data_out` out: selected master's fields.
- `a_source_out` out `SRC_WIDTH+MIDX_W`: {master index, `a_source`}.
- `d_valid_in` in 1; `d_ready_in` out 1; `d_opcode_in`, `d_param_in`, `d_size_in`, `d_sink_in`, `d_data_in`, `d_error_in` in: slave-side D.
- `d_source_in` in `SRC_WIDTH+MIDX_W`: widened source of the response.
- `drop_pulse` out 1: one-cycle pulse when a D beat with an out-of-range master index is discarded.

## Operation
- **Opcodes.** A: PutFullData=0, PutPartialData=1, Get=4. D: AccessAck=0, AccessAckData=1.
- **Beat count.** `beats = 1` if `size ≤ log2(DATA_WIDTH/8)`, else `2^(size−log2(DATA_WIDTH/8))`. Put requests and AccessAckData responses use this count; Get and AccessAck are single-beat. Beat counters are 8 bits wide.
- **Eligibility.** Master m is eligible when `a_valid[m]` is high and `outstanding[m] < MAX_OUTSTANDING`.
- **IDLE.** The winner is chosen combinationally among eligible masters.
  - Round-robin: first eligible index at or after `rr_ptr`, wrapping modulo `NUM_MASTERS`.
  - Fixed priority: lowest eligible index.
  - Winner drives `a_*_out`. `a_ready[winner] = a_ready_out`; all other `a_ready` bits are 0.
  - Handshake on a single-beat request: stay IDLE and set `rr_ptr = winner+1` (wraps to 0).
  - Handshake on the first beat of a multi-beat Put: go to BURST with `lock = winner` and `beats_left = beats−1`.
  - Winner valid but `a_ready_out` low: go to HOLD with `lock = winner`. A presented request is never re-arbitrated away.
  - No eligible master: `a_valid_out = 0`.
- **HOLD.** Drive from `lock`, ignoring eligibility. On handshake, apply the IDLE handshake rules for `lock`.
- **BURST.** Drive from `lock`. Each handshake decrements `beats_left`. The handshake taken at `beats_left == 1` returns to IDLE and sets `rr_ptr = lock+1`. Other masters see `a_ready = 0` throughout.
- **Outstanding counters.**
  - `outstanding[m]` increments on the first A beat of a request from m.
  - It decrements on the last D beat routed to m. D beats are tracked by a D-side `d_beats_left` counter.
  - Simultaneous increment and decrement for the same m leaves the count unchanged.
  - The counter never exceeds `MAX_OUTSTANDING`.
- **D routing.** `idx = d_source_in[SRC_WIDTH +: MIDX_W]`.
  - If `idx < NUM_MASTERS`: `d_valid[idx] = d_valid_in` and `d_ready_in = d_ready[idx]`.
  - Otherwise: `d_ready_in = 1`, all `d_valid` bits are 0, and `drop_pulse` fires once per dropped beat.
- **Reset.** While `reset` is high:
  - state = IDLE, `rr_ptr = 0`, all counters = 0;
  - `a_valid_out`, `a_ready`, `d_valid`, `d_ready_in`, `drop_pulse` are forced to 0;
  - data outputs are don't-care.

  Reset asserted mid-burst or mid-HOLD aborts the transfer. The first cycle after reset deasserts behaves as IDLE.

## Timing
- A path: zero-cycle combinational pass-through (`a_valid` to `a_valid_out`, `a_ready_out` to `a_ready`). State updates on the `clk` edge after each handshake.
- D path: fully combinational, zero latency.
- Back-to-back single-beat requests complete one per cycle with no bubble.
- `rr_ptr`, `lock`, `beats_left`, and the outstanding counters are registered and take effect the next cycle.

## Test plan
- **Round-robin fairness.** `ARB_MODE=0`, masters 0–3 hold single-beat Gets, `a_ready_out=1` -> grants 0,1,2,3,0 on consecutive cycles; `a_source_out` upper bits match the grant.
- **HOLD.** Master 2 valid, `a_ready_out=0` for 3 cycles while master 0 also asserts -> `a_valid_out` stays on master 2's fields until the handshake; master 0 gets `a_ready=0`.
- **BURST.** PutFullData size=4 (16 B, 4 beats) from master 1 with master 3 also valid -> 4 consecutive beats from master 1 before master 3's first grant.
- **Outstanding limit.** `MAX_OUTSTANDING=2`, master 0 issues 2 Gets with no response -> third request not granted. After one AccessAck with `d_source_in={0,src}`, it is granted the next cycle.
- **D routing.** `d_source_in={2'd3,2'd1}` -> only `d_valid[3]` high and `d_source` slice = 1. Out-of-range index with `NUM_MASTERS=3` -> `d_ready_in=1`, `drop_pulse=1`, no `d_valid`.
- **Reset mid-burst.** Reset asserted after beat 2 of 4 -> outputs 0 during reset; IDLE afterwards, counters 0, new Get granted.
